// File: rtl/serial_frame_deserializer_if.sv
// Output-side valid/ready bus of the serial frame deserializer.
// The master drives the assembled word and status pulses; the slave returns ready.
interface serial_frame_deserializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  modport master (
    output data_out,
    output valid_out,
    output parity_err,
    output frame_err,
    output overrun,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output ready_in
  );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: start bit (1), WIDTH data bits LSB-first,
// optional even-parity bit, stop bit (0). Good frames are presented as one
// held parallel word on a valid/ready bus; badly framed words are discarded
// with a frame_err pulse, and good frames arriving while the word is still
// held are dropped with an overrun pulse.
module serial_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_d,
  serial_frame_deserializer_if.master   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Even parity over the data word and the received parity bit; 1 = mismatch.
  function automatic logic parity_mismatch(input logic [WIDTH-1:0] data, input logic par);
    parity_mismatch = (^data) ^ par;
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_accept;
  logic             w_perr_new;

  // A held word leaves the output at an edge where valid and ready are both high.
  assign w_accept   = r_valid & bus.ready_in;
  assign w_perr_new = (PARITY_EN != 0) ? parity_mismatch(r_shift, r_par) : 1'b0;

  assign bus.data_out   = r_data;
  assign bus.valid_out  = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;

  // Frame FSM plus registered output word, handshake and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Status pulses last exactly one cycle.
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      // Consumer takes the word; a load in STOP below may refill it at this same edge.
      if (w_accept) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end

      case (r_state)
        S_IDLE: begin
          if (i_d) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          // Shift right so the first (LSB) bit ends up in bit 0.
          r_shift <= {i_d, r_shift[WIDTH-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_PARITY: begin
          r_par   <= i_d;
          r_state <= S_STOP;
        end
        S_STOP: begin
          // Stop bit of 1 is a framing error and is never reused as a start bit.
          r_state <= S_IDLE;
          if (!i_d) begin
            if (!r_valid || w_accept) begin
              r_data  <= r_shift;
              r_perr  <= w_perr_new;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
          end else begin
            r_ferr <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
